mem_ctrl_arb: RTL and testbench

Memory controller and arbiter between the instruction fetch unit and the load/store buffer, sharing one byte-wide synchronous RAM port. Splits word/half/byte requests into serial byte accesses, assembles load data little-endian, and signals completion. Handles rollback (clr) aborts and stalls IO-region writes while the IO buffer is full.

---
 rtl/mem_ctrl_arb.sv | 178 +++++++++++++++++
 tb/tb_mem_ctrl_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: arbitrates instruction fetch and LSB onto one byte-wide RAM port, serialising multi-byte accesses.
// Optional MC_IO_STALL_EN: IO-region stores wait for io_buffer_full to drop before their first byte.
module mem_ctrl_arb #(
    parameter int ADDR_W      = 32,
    parameter int FETCH_BYTES = 4,
    parameter int IO_SEL_HI   = 17,
    parameter int IO_SEL_LO   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_en,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_ls_type,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_st_val,
    output logic              ld_done,
    output logic [31:0]       ld_val,
    output logic              st_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, COOL} state_t;
    state_t state_q, state_d;
    logic last_lsb_q, last_lsb_d, pend_q, pend_d;
    logic [2:0] cnt_q, cnt_d, len_q, len_d, lsb_len;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
    logic [31:0] st_q, st_d, buf_q, buf_d, if_data_q, if_data_d, ld_val_q, ld_val_d;
    logic [7:0] dout_q, dout_d;
    logic wr_q, wr_d, if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
    logic io_full, take_if, grant_lsb, lsb_stall;

`ifdef MC_IO_STALL_EN
    assign io_full = io_buffer_full;
`else
    assign io_full = io_buffer_full & 1'b0;
`endif

    assign lsb_len   = lsb_ls_type == 2'd0 ? 3'd1 : lsb_ls_type == 2'd1 ? 3'd2 : 3'd4;
    // A rollback only cancels the fetch side in IDLE; the LSB may still hold a committed store.
    assign take_if   = if_req && !clr;
    assign grant_lsb = lsb_en && (!take_if || !last_lsb_q);
    assign lsb_stall = lsb_wr && (&lsb_addr[IO_SEL_HI:IO_SEL_LO]) && io_full;

    always_comb begin
        state_d    = state_q;
        last_lsb_d = last_lsb_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        addr_d     = addr_q;
        mem_a_d    = mem_a_q;
        st_d       = st_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ld_val_d   = ld_val_q;
        dout_d     = 8'h00;
        wr_d       = 1'b0;
        if_done_d  = 1'b0;
        ld_done_d  = 1'b0;
        st_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_lsb) begin
                    state_d    = lsb_wr ? STORE : LOAD;
                    last_lsb_d = 1'b1;
                    addr_d     = lsb_addr;
                    mem_a_d    = lsb_addr;
                    len_d      = lsb_len;
                    st_d       = lsb_st_val;
                    buf_d      = '0;
                    cnt_d      = '0;
                    pend_d     = lsb_stall;
                    wr_d       = lsb_wr && !lsb_stall;
                    dout_d     = wr_d ? lsb_st_val[7:0] : 8'h00;
                end else if (take_if) begin
                    state_d    = FETCH;
                    last_lsb_d = 1'b0;
                    addr_d     = if_addr;
                    mem_a_d    = if_addr;
                    len_d      = 3'(FETCH_BYTES);
                    buf_d      = '0;
                    cnt_d      = '0;
                end
            end
            FETCH, LOAD: begin
                if (clr) begin
                    state_d = IDLE;
                end else begin
                    // mem_din lags the address by one cycle, so byte cnt-1 arrives now.
                    if (cnt_q != 3'd0)
                        buf_d = buf_q | (32'(mem_din) << {cnt_q - 3'd1, 3'd0});
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d < len_q)
                        mem_a_d = addr_q + ADDR_W'(cnt_d);
                    if (cnt_q == len_q) begin
                        state_d   = COOL;
                        if_done_d = state_q == FETCH;
                        ld_done_d = state_q == LOAD;
                        if_data_d = state_q == FETCH ? buf_d : if_data_q;
                        ld_val_d  = state_q == LOAD ? buf_d : ld_val_q;
                    end
                end
            end
            STORE: begin
                if (pend_q) begin
                    pend_d = io_full;
                    wr_d   = !io_full;
                    dout_d = io_full ? 8'h00 : st_q[7:0];
                end else if (cnt_q + 3'd1 < len_q) begin
                    cnt_d   = cnt_q + 3'd1;
                    wr_d    = 1'b1;
                    mem_a_d = addr_q + ADDR_W'(cnt_d);
                    dout_d  = 8'(st_q >> {cnt_d, 3'd0});
                end else begin
                    st_done_d = 1'b1;
                    state_d   = COOL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_lsb_q <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            mem_a_q    <= '0;
            st_q       <= '0;
            buf_q      <= '0;
            if_data_q  <= '0;
            ld_val_q   <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            last_lsb_q <= last_lsb_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            mem_a_q    <= mem_a_d;
            st_q       <= st_d;
            buf_q      <= buf_d;
            if_data_q  <= if_data_d;
            ld_val_q   <= ld_val_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
        end
    end

    assign mem_wr   = wr_q & rdy;
    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ld_done  = ld_done_q;
    assign ld_val   = ld_val_q;
    assign st_done  = st_done_q;
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// tb_mem_ctrl_arb: directed timeline for mem_ctrl_arb with a queue scoreboard checked by an independent monitor.
module tb_mem_ctrl_arb;
    logic clk = 0, rst = 1, rdy = 1, clr = 0, if_req = 0, lsb_en = 0, lsb_wr = 0, io_buffer_full = 0;
    logic [31:0] if_addr = 0, lsb_addr = 0, lsb_st_val = 0;
    logic [1:0] lsb_ls_type = 0;
    logic if_done, ld_done, st_done, mem_wr;
    logic [31:0] if_data, ld_val, mem_a;
    logic [7:0] mem_din, mem_dout;
    int cyc = 0, errors = 0, checks = 0;
    typedef struct {logic [31:0] a; logic [31:0] d; int c;} exp_t;
    exp_t q_if[$], q_ld[$], q_st[$], q_wr[$];
    exp_t em;
    logic [7:0] ram [0:262143];

    mem_ctrl_arb dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_ls_type(lsb_ls_type), .lsb_addr(lsb_addr),
        .lsb_st_val(lsb_st_val), .ld_done(ld_done), .ld_val(ld_val), .st_done(st_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte RAM, frozen together with the rest of the system while rdy is low.
    always @(posedge clk) begin
        if (rst) begin
            ram[18'h01000] <= 8'h13; ram[18'h01001] <= 8'h05; ram[18'h01002] <= 8'h00; ram[18'h01003] <= 8'h00;
            ram[18'h01004] <= 8'h93; ram[18'h01005] <= 8'h00; ram[18'h01006] <= 8'h10; ram[18'h01007] <= 8'h00;
            ram[18'h00020] <= 8'hEF; ram[18'h00021] <= 8'hBE; ram[18'h00022] <= 8'hAD; ram[18'h00023] <= 8'hDE;
        end else if (rdy) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if_done) begin
                if (q_if.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_done: got unexpected pulse at cycle %0d, expected none", cyc);
                end else begin
                    em = q_if.pop_front();
                    chk("if_data", if_data, em.d);
                    chk("if_done cycle", cyc, em.c);
                end
            end
            if (ld_done) begin
                if (q_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ld_done: got unexpected pulse at cycle %0d, expected none", cyc);
                end else begin
                    em = q_ld.pop_front();
                    chk("ld_val", ld_val, em.d);
                    chk("ld_done cycle", cyc, em.c);
                end
            end
            if (st_done) begin
                if (q_st.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL st_done: got unexpected pulse at cycle %0d, expected none", cyc);
                end else begin
                    em = q_st.pop_front();
                    chk("st_done cycle", cyc, em.c);
                end
            end
            if (mem_wr) begin
                if (q_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_wr: got unexpected write a=%0h d=%0h at cycle %0d, expected none", mem_a, mem_dout, cyc);
                end else begin
                    em = q_wr.pop_front();
                    chk("mem_a write", mem_a, em.a);
                    chk("mem_dout write", 32'(mem_dout), em.d);
                    chk("mem_wr cycle", cyc, em.c);
                end
            end else begin
                chk("mem_dout idle", 32'(mem_dout), 0);
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst if_done", 32'(if_done), 0);
        chk("rst ld_done", 32'(ld_done), 0);
        chk("rst st_done", 32'(st_done), 0);
        chk("rst mem_wr", 32'(mem_wr), 0);
        chk("rst mem_a", mem_a, 0);
        chk("rst mem_dout", 32'(mem_dout), 0);
        chk("rst if_data", if_data, 0);
        chk("rst ld_val", ld_val, 0);
        rst = 0;
        @(negedge clk);
        // Word fetch: done 6 cycles after sampling.
        c = cyc;
        if_req = 1; if_addr = 32'h1000;
        q_if.push_back('{32'h1000, 32'h0000_0513, c + 6});
        at(c + 6); if_req = 0;
        // Simultaneous requests after an IF grant: LSB first, fetch one cycle after ld_done.
        at(c + 7); c = cyc;
        lsb_en = 1; lsb_wr = 0; lsb_ls_type = 2; lsb_addr = 32'h20;
        if_req = 1; if_addr = 32'h1004;
        q_ld.push_back('{32'h20, 32'hDEAD_BEEF, c + 6});
        q_if.push_back('{32'h1004, 32'h0010_0093, c + 13});
        at(c + 6); lsb_en = 0;
        at(c + 13); if_req = 0;
        // Half store, then read it back zero-extended.
        at(c + 14); c = cyc;
        lsb_en = 1; lsb_wr = 1; lsb_ls_type = 1; lsb_addr = 32'h101; lsb_st_val = 32'h1234_ABCD;
        q_wr.push_back('{32'h101, 32'hCD, c + 1});
        q_wr.push_back('{32'h102, 32'hAB, c + 2});
        q_st.push_back('{32'h101, 32'h0, c + 3});
        at(c + 3); lsb_en = 0;
        at(c + 4); c = cyc;
        lsb_en = 1; lsb_wr = 0; lsb_ls_type = 1; lsb_addr = 32'h101;
        q_ld.push_back('{32'h101, 32'h0000_ABCD, c + 4});
        at(c + 4); lsb_en = 0;
        // Rollback during the second byte of a word load: no done, IDLE next cycle.
        at(c + 5); c = cyc;
        lsb_en = 1; lsb_ls_type = 2; lsb_addr = 32'h20;
        at(c + 2); clr = 1; lsb_en = 0;
        at(c + 3); clr = 0;
        lsb_en = 1; lsb_ls_type = 0; lsb_addr = 32'h23;
        q_ld.push_back('{32'h23, 32'hDE, c + 6});
        at(c + 6); lsb_en = 0;
        // Rollback in IDLE masks the fetch even though it would win arbitration.
        at(c + 7); c = cyc;
        clr = 1; if_req = 1; if_addr = 32'h1000;
        lsb_en = 1; lsb_ls_type = 0; lsb_addr = 32'h21;
        q_ld.push_back('{32'h21, 32'hBE, c + 3});
        q_if.push_back('{32'h1000, 32'h0000_0513, c + 10});
        at(c + 1); clr = 0;
        at(c + 3); lsb_en = 0;
        at(c + 10); if_req = 0;
        // Rollback during a committed byte store does not cancel it.
        at(c + 11); c = cyc;
        lsb_en = 1; lsb_wr = 1; lsb_ls_type = 0; lsb_addr = 32'h200; lsb_st_val = 32'h5A;
        q_wr.push_back('{32'h200, 32'h5A, c + 1});
        q_st.push_back('{32'h200, 32'h0, c + 2});
        at(c + 1); clr = 1;
        at(c + 2); clr = 0; lsb_en = 0;
        // IO-region byte store with the IO buffer full.
        at(c + 3); c = cyc;
        lsb_en = 1; lsb_wr = 1; lsb_ls_type = 0; lsb_addr = 32'h3_0000; lsb_st_val = 32'h41;
        io_buffer_full = 1;
`ifdef MC_IO_STALL_EN
        q_wr.push_back('{32'h3_0000, 32'h41, c + 4});
        q_st.push_back('{32'h3_0000, 32'h0, c + 5});
        at(c + 3); io_buffer_full = 0;
        at(c + 5); lsb_en = 0;
`else
        q_wr.push_back('{32'h3_0000, 32'h41, c + 1});
        q_st.push_back('{32'h3_0000, 32'h0, c + 2});
        at(c + 2); lsb_en = 0;
        at(c + 3); io_buffer_full = 0;
`endif
        // Continuous requests alternate IF, LSB, IF; rdy low for two cycles mid-fetch.
        at(c + 6); c = cyc;
        if_req = 1; if_addr = 32'h1000;
        lsb_en = 1; lsb_wr = 0; lsb_ls_type = 0; lsb_addr = 32'h20;
        q_if.push_back('{32'h1000, 32'h0000_0513, c + 6});
        q_ld.push_back('{32'h20, 32'hEF, c + 10});
        q_if.push_back('{32'h1000, 32'h0000_0513, c + 19});
        at(c + 13); chk("mem_a before freeze", mem_a, 32'h1001); rdy = 0;
        at(c + 14); chk("mem_a frozen 1", mem_a, 32'h1001);
        at(c + 15); chk("mem_a frozen 2", mem_a, 32'h1001); rdy = 1;
        at(c + 16); chk("mem_a resumed", mem_a, 32'h1002);
        at(c + 19); if_req = 0; lsb_en = 0;
        at(c + 24);
        chk("if queue drained", q_if.size(), 0);
        chk("ld queue drained", q_ld.size(), 0);
        chk("st queue drained", q_st.size(), 0);
        chk("wr queue drained", q_wr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
